sha256_padder: RTL and testbench

- Upstream stage of the SHA-256 hash top. Accepts a 32-bit big-endian message word stream with valid/ready handshaking.
- Applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit message bit length.
- Emits 512-bit blocks over a valid/ready interface, with first/last flags for the core's block input and hash-reset control.

---
 rtl/sha256_pkg.sv | 18 +
 rtl/sha256_padder_insert.sv | 24 ++
 rtl/sha256_padder.sv | 198 +++++++++++++++++++
 tb/tb_sha256_padder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 padding front end.
package sha256_pkg;

   localparam int BlockWidth = 512;
   localparam int WordWidth  = 32;
   localparam int LenWidth   = 64;
   localparam int NumWords   = BlockWidth / WordWidth;

   // First pad word when the message ends exactly on a word boundary
   localparam logic [WordWidth-1:0] MarkerWord = 32'h8000_0000;

   typedef enum logic [1:0] {
      S_FILL,
      S_PAD,
      S_OUT
   } state_e;

endpackage

// File: rtl/sha256_padder_insert.sv
// Keeps the leading valid bytes of a left-aligned message word, clears the
// rest, and optionally drops the 0x80 marker into the first unused byte.
module sha256_padder_insert
   import sha256_pkg::*;
(
   input  logic [WordWidth-1:0] data_i,
   input  logic [2:0]           bytes_i,
   input  logic                 marker_i,
   output logic [WordWidth-1:0] word_o
);

   // Byte lane select: data, marker, or zero
   always_comb begin
      word_o = '0;
      for (int b = 0; b < 4; b++) begin
         if (3'(b) < bytes_i) begin
            word_o[31-8*b -: 8] = data_i[31-8*b -: 8];
         end else if (marker_i && (3'(b) == bytes_i)) begin
            word_o[31-8*b -: 8] = 8'h80;
         end
      end
   end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit message words into 512-bit blocks,
// appends the 0x80 marker, zero fill and the 64-bit bit length.
// Optional sticky length error enabled by defining SHA_PADDER_LEN_ERR_EN.
module sha256_padder
   import sha256_pkg::*;
#(
   parameter int MaxBlocks = 0,
   parameter int LenWidth  = sha256_pkg::LenWidth
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [WordWidth-1:0]  msg_data_i,
   input  logic [2:0]            msg_bytes_i,
   input  logic                  msg_last_i,
   input  logic                  msg_valid_i,
   output logic                  msg_ready_o,
   output logic [BlockWidth-1:0] block_o,
   output logic                  block_first_o,
   output logic                  block_last_o,
   output logic                  block_valid_o,
   input  logic                  block_ready_i,
   output logic                  len_err_o
);

   state_e               r_state;
   logic [WordWidth-1:0] r_buf [NumWords];
   logic [4:0]           r_idx;            // 0..16; 16 means the block is full
   logic [LenWidth-1:0]  r_bitcnt;
   logic                 r_first_pending;
   logic                 r_marker_pending;  // word-aligned end, marker still owed
   logic                 r_need_len;        // length did not fit, another block follows
   logic                 r_len_hi;          // upper length word already written at 14
   logic                 r_last;
   logic                 r_msg_ready;
   logic                 r_blk_valid;

   logic                 w_accept;
   logic                 w_handshake;
   logic [3:0]           w_widx;
   logic [WordWidth-1:0] w_ins_word;
   logic [LenWidth-1:0]  w_bitcnt_nxt;
   logic                 w_cnt_carry;

   assign w_accept    = msg_valid_i & r_msg_ready;
   assign w_handshake = r_blk_valid & block_ready_i;
   assign w_widx      = r_idx[3:0];
   assign {w_cnt_carry, w_bitcnt_nxt} = {1'b0, r_bitcnt}
                                      + {{(LenWidth-5){1'b0}}, msg_bytes_i, 3'b000};

   sha256_padder_insert u_insert (
      .data_i   (msg_data_i),
      .bytes_i  (msg_bytes_i),
      .marker_i (msg_last_i),
      .word_o   (w_ins_word)
   );

   // Control FSM plus buffer writes; outputs registered alongside the state
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state          <= S_FILL;
         r_idx            <= '0;
         r_bitcnt         <= '0;
         r_first_pending  <= 1'b1;
         r_marker_pending <= 1'b0;
         r_need_len       <= 1'b0;
         r_len_hi         <= 1'b0;
         r_last           <= 1'b0;
         r_msg_ready      <= 1'b0;
         r_blk_valid      <= 1'b0;
         for (int i = 0; i < NumWords; i++) r_buf[i] <= '0;
      end else begin
         case (r_state)
            S_FILL: begin
               r_msg_ready <= 1'b1;
               if (w_accept) begin
                  r_buf[w_widx] <= w_ins_word;
                  r_bitcnt      <= w_bitcnt_nxt;
                  r_idx         <= r_idx + 5'd1;
                  if (!msg_last_i) begin
                     if (w_widx == 4'd15) begin
                        r_state     <= S_OUT;
                        r_last      <= 1'b0;
                        r_msg_ready <= 1'b0;
                        r_blk_valid <= 1'b1;
                     end
                  end else if (msg_bytes_i < 3'd4) begin
                     r_state     <= S_PAD;
                     r_msg_ready <= 1'b0;
                  end else begin
                     r_marker_pending <= 1'b1;
                     r_msg_ready      <= 1'b0;
                     if (w_widx == 4'd15) begin
                        r_state     <= S_OUT;
                        r_last      <= 1'b0;
                        r_blk_valid <= 1'b1;
                     end else begin
                        r_state <= S_PAD;
                     end
                  end
               end
            end
            S_PAD: begin
               if (r_idx[4]) begin
                  r_state     <= S_OUT;
                  r_last      <= 1'b0;
                  r_need_len  <= 1'b1;
                  r_blk_valid <= 1'b1;
               end else if (r_marker_pending) begin
                  r_buf[w_widx]    <= MarkerWord;
                  r_marker_pending <= 1'b0;
                  r_idx            <= r_idx + 5'd1;
               end else if (w_widx == 4'd14) begin
                  r_buf[w_widx] <= r_bitcnt[LenWidth-1 -: 32];
                  r_len_hi      <= 1'b1;
                  r_idx         <= r_idx + 5'd1;
               end else if ((w_widx == 4'd15) && r_len_hi) begin
                  r_buf[w_widx] <= r_bitcnt[31:0];
                  r_idx         <= r_idx + 5'd1;
                  r_state       <= S_OUT;
                  r_last        <= 1'b1;
                  r_blk_valid   <= 1'b1;
               end else begin
                  r_buf[w_widx] <= '0;
                  r_idx         <= r_idx + 5'd1;
               end
            end
            S_OUT: begin
               if (block_ready_i) begin
                  for (int i = 0; i < NumWords; i++) r_buf[i] <= '0;
                  r_idx       <= '0;
                  r_blk_valid <= 1'b0;
                  r_need_len  <= 1'b0;
                  r_len_hi    <= 1'b0;
                  if (r_last) begin
                     r_first_pending <= 1'b1;
                     r_bitcnt        <= '0;
                     r_state         <= S_FILL;
                     r_msg_ready     <= 1'b1;
                  end else begin
                     r_first_pending <= 1'b0;
                     if (r_need_len || r_marker_pending) begin
                        r_state <= S_PAD;
                     end else begin
                        r_state     <= S_FILL;
                        r_msg_ready <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               r_state     <= S_FILL;
               r_msg_ready <= 1'b0;
               r_blk_valid <= 1'b0;
            end
         endcase
      end
   end

   // Word 0 of the buffer lands in the most significant bits of the block
   always_comb begin
      block_o = '0;
      for (int i = 0; i < NumWords; i++) begin
         block_o[BlockWidth-1-WordWidth*i -: WordWidth] = r_buf[i];
      end
   end

   assign msg_ready_o   = r_msg_ready;
   assign block_valid_o = r_blk_valid;
   assign block_first_o = r_blk_valid & r_first_pending;
   assign block_last_o  = r_blk_valid & r_last;

`ifdef SHA_PADDER_LEN_ERR_EN
   logic        r_len_err;
   logic [31:0] r_blkcnt;
   logic        w_blk_err;

   assign w_blk_err = (MaxBlocks > 0) && w_handshake
                    && ((r_blkcnt + 32'd1) > 32'(MaxBlocks));

   // Sticky error on length overflow or too many blocks in one message
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_len_err <= 1'b0;
         r_blkcnt  <= '0;
      end else begin
         if ((w_accept && w_cnt_carry) || w_blk_err) r_len_err <= 1'b1;
         if (w_handshake) r_blkcnt <= r_last ? 32'd0 : (r_blkcnt + 32'd1);
      end
   end

   assign len_err_o = r_len_err;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = w_cnt_carry | (MaxBlocks != 0) | w_handshake;
   assign len_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench for sha256_padder: directed messages with hand-computed blocks.
module tb_sha256_padder;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [31:0]  msg_data_i;
   logic [2:0]   msg_bytes_i;
   logic         msg_last_i;
   logic         msg_valid_i;
   logic         msg_ready_o;
   logic [511:0] block_o;
   logic         block_first_o;
   logic         block_last_o;
   logic         block_valid_o;
   logic         block_ready_i;
   logic         len_err_o;

   typedef struct {
      logic [511:0] data;
      logic         first;
      logic         last;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fails  = 0;

   localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
   localparam logic [511:0] B56_1     = {{14{32'h61616161}}, 32'h80000000, 32'h0};
   localparam logic [511:0] B56_2     = {480'h0, 32'h000001C0};
   localparam logic [511:0] B64_1     = {16{32'h61616161}};
   localparam logic [511:0] B64_2     = {32'h80000000, 448'h0, 32'h00000200};

   sha256_padder dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .msg_data_i    (msg_data_i),
      .msg_bytes_i   (msg_bytes_i),
      .msg_last_i    (msg_last_i),
      .msg_valid_i   (msg_valid_i),
      .msg_ready_o   (msg_ready_o),
      .block_o       (block_o),
      .block_first_o (block_first_o),
      .block_last_o  (block_last_o),
      .block_valid_o (block_valid_o),
      .block_ready_i (block_ready_i),
      .len_err_o     (len_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [511:0] d, input logic f, input logic l);
      exp_t e;
      e.data  = d;
      e.first = f;
      e.last  = l;
      sb_q.push_back(e);
   endtask

   // Monitor: one sample per block handshake, taken on the falling edge
   always @(negedge clk_i) begin
      exp_t e;
      if (!rst_i && block_valid_o && block_ready_i) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_block: got %h required none", block_o);
         end else begin
            e = sb_q.pop_front();
            check("block_data", block_o, e.data);
            check("block_first", 512'(block_first_o), 512'(e.first));
            check("block_last", 512'(block_last_o), 512'(e.last));
         end
      end
   end

   task automatic send_word(input logic [31:0] d, input logic [2:0] b, input logic l);
      int n;
      @(negedge clk_i);
      msg_data_i  = d;
      msg_bytes_i = b;
      msg_last_i  = l;
      msg_valid_i = 1'b1;
      n = 0;
      while (!msg_ready_o && n < 500) begin
         @(negedge clk_i);
         n++;
      end
      if (!msg_ready_o) begin
         n_checks++;
         n_fails++;
         $display("FAIL word_accept_timeout: ready=%0b required 1", msg_ready_o);
      end
      @(posedge clk_i);
      #1 msg_valid_i = 1'b0;
   endtask

   task automatic send_fill(input int nbytes);
      int rem;
      int k;
      logic [31:0] mask;
      if (nbytes == 0) begin
         send_word(32'h0, 3'd0, 1'b1);
      end else begin
         rem = nbytes;
         while (rem > 0) begin
            k = (rem >= 4) ? 4 : rem;
            mask = 32'hFFFF_FFFF << (8 * (4 - k));
            send_word(32'h61616161 & mask, 3'(k), (rem == k));
            rem -= k;
         end
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 300) begin
         @(negedge clk_i);
         n++;
      end
      if (sb_q.size() != 0) begin
         n_checks++;
         n_fails++;
         $display("FAIL drain_timeout: pending=%0d required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_i         = 1'b1;
      msg_data_i    = '0;
      msg_bytes_i   = '0;
      msg_last_i    = 1'b0;
      msg_valid_i   = 1'b0;
      block_ready_i = 1'b1;
      repeat (3) @(negedge clk_i);
      check("rst_block_valid", 512'(block_valid_o), 512'(0));
      check("rst_msg_ready", 512'(msg_ready_o), 512'(0));
      check("rst_block_first", 512'(block_first_o), 512'(0));
      check("rst_block_last", 512'(block_last_o), 512'(0));
      check("rst_len_err", 512'(len_err_o), 512'(0));
      rst_i = 1'b0;
      @(negedge clk_i);
      check("post_rst_ready", 512'(msg_ready_o), 512'(1));

      // "abc"
      push_exp(ABC_BLK, 1'b1, 1'b1);
      send_word(32'h61626300, 3'd3, 1'b1);
      wait_drain();

      // empty message
      push_exp(EMPTY_BLK, 1'b1, 1'b1);
      send_fill(0);
      wait_drain();

      // 56 bytes: length spills into a second block
      push_exp(B56_1, 1'b1, 1'b0);
      push_exp(B56_2, 1'b0, 1'b1);
      send_fill(56);
      wait_drain();

      // 64 bytes: marker opens the second block
      push_exp(B64_1, 1'b1, 1'b0);
      push_exp(B64_2, 1'b0, 1'b1);
      send_fill(64);
      wait_drain();

      // backpressure on the block output
      block_ready_i = 1'b0;
      push_exp(ABC_BLK, 1'b1, 1'b1);
      send_word(32'h61626300, 3'd3, 1'b1);
      n = 0;
      while (!block_valid_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      check("stall_valid_seen", 512'(block_valid_o), 512'(1));
      msg_data_i  = 32'h0;
      msg_bytes_i = 3'd0;
      msg_last_i  = 1'b1;
      msg_valid_i = 1'b1;
      push_exp(EMPTY_BLK, 1'b1, 1'b1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_i);
         check("stall_block", block_o, ABC_BLK);
         check("stall_flags", 512'({block_valid_o, block_first_o, block_last_o}), 512'(3'b111));
         check("stall_msg_ready", 512'(msg_ready_o), 512'(0));
      end
      @(posedge clk_i);
      #1 block_ready_i = 1'b1;
      n = 0;
      while (!msg_ready_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      check("stall_release_ready", 512'(msg_ready_o), 512'(1));
      @(posedge clk_i);
      #1 msg_valid_i = 1'b0;
      wait_drain();

      // reset in the middle of a message
      for (int w = 0; w < 5; w++) send_word(32'h61616161, 3'd4, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      check("midrst_valid", 512'(block_valid_o), 512'(0));
      check("midrst_ready", 512'(msg_ready_o), 512'(0));
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      push_exp(ABC_BLK, 1'b1, 1'b1);
      send_word(32'h61626300, 3'd3, 1'b1);
      wait_drain();

      check("final_len_err", 512'(len_err_o), 512'(0));
      repeat (2) @(negedge clk_i);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
